mem_xbar: RTL

Parametrised memory-bus interconnect replacing fixed address decoding between bus masters and memory/peripheral slaves. Connects NM valid/ready masters (e.g. core, DMA) to NS address-mapped slaves (RAM, SPI flash, config register, iomem) with round-robin arbitration, parameter-driven address decode, decode-error reporting and a per-transaction timeout. One transaction is in flight at a time; responses are registered.

---
 rtl/mem_xbar.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_xbar.sv
// mem_xbar: round-robin interconnect from NM valid/ready masters to NS address-mapped
// slaves. One transaction is in flight at a time, and the master-side response is registered.
module mem_xbar #(
  parameter int                 NM         = 2,
  parameter int                 NS         = 4,
  parameter logic [NS*32-1:0]   SLAVE_BASE = {32'h0000_0000, 32'h0300_0000,
                                              32'h0100_0000, 32'h0000_0000},
  parameter logic [NS*32-1:0]   SLAVE_MASK = {32'hFFFF_F000, 32'hFF00_0000,
                                              32'hFF00_0000, 32'hFFFF_FC00},
  parameter int unsigned        TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NM-1:0]     m_valid,
  output logic [NM-1:0]     m_ready,
  input  logic [NM*32-1:0]  m_addr,
  input  logic [NM*32-1:0]  m_wdata,
  input  logic [NM*4-1:0]   m_wstrb,
  output logic [31:0]       m_rdata,
  output logic              m_error,
  output logic [NS-1:0]     s_valid,
  input  logic [NS-1:0]     s_ready,
  output logic [31:0]       s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [NS*32-1:0]  s_rdata
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] BUSY   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [GW-1:0] g_q, g_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // Round-robin search starting just after the last master served.
  logic          gnt_found;
  logic [GW-1:0] gnt_idx;
  logic [GW-1:0] cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NM; k++) begin
      cand = GW'((int'(last_grant_q) + 1 + k) % NM);
      if (!gnt_found && m_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  logic          sel_found;
  logic [SW-1:0] sel_idx;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((addr_q & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        sel_found = 1'b1;
        sel_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every _d takes its held value first, so no path through the case leaves a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    g_d          = g_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          g_d     = gnt_idx;
          addr_d  = m_addr[32*gnt_idx +: 32];
          wdata_d = m_wdata[32*gnt_idx +: 32];
          wstrb_d = m_wstrb[4*gnt_idx +: 4];
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (sel_found) begin
          sel_d   = sel_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      BUSY: begin
        // A slave answering on the same cycle the timer expires still wins.
        if (s_ready[sel_q]) begin
          rdata_d = s_rdata[32*sel_q +: 32];
          err_d   = 1'b0;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT))) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP: begin
        last_grant_d = g_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NM - 1);
      g_q          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      g_q          <= g_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Handshake outputs are decoded from registered state only.
  always_comb begin
    m_ready = '0;
    s_valid = '0;
    for (int i = 0; i < NM; i++) begin
      m_ready[i] = (state_q == RESP) && (g_q == GW'(i));
    end
    for (int i = 0; i < NS; i++) begin
      s_valid[i] = (state_q == BUSY) && (sel_q == SW'(i));
    end
  end

  assign m_rdata = rdata_q;
  assign m_error = err_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_wstrb = wstrb_q;

endmodule
